spi_master_00: RTL and testbench

SPI_MASTER_00 -- requirements
Module: spi_master_00

---
 rtl/spi_master_00_if.sv | 23 ++
 rtl/spi_master_00.sv | 193 +++++++++++++++++++
 tb/tb_spi_master_00.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_00_if.sv
// Host handshake and SPI pin bundle for spi_master_00.
// master: the SPI master side; slave: the side that drives requests and MISO.
interface spi_master_00_if;
  logic [7:0] i_TX_DATA;
  logic       i_TX_DV;
  logic       o_TX_READY;
  logic [7:0] o_RX_DATA;
  logic       o_RX_DV;
  logic       o_SCLK;
  logic       o_SS;
  logic       o_MOSI;
  logic       i_MISO;

  modport master (
    input  i_TX_DATA, i_TX_DV, i_MISO,
    output o_TX_READY, o_RX_DATA, o_RX_DV, o_SCLK, o_SS, o_MOSI
  );

  modport slave (
    output i_TX_DATA, i_TX_DV, i_MISO,
    input  o_TX_READY, o_RX_DATA, o_RX_DV, o_SCLK, o_SS, o_MOSI
  );
endinterface

// File: rtl/spi_master_00.sv
// SPI master, mode 0 (CPOL=0/CPHA=0), LSB first, 8-bit frames.
// Define SPI_MASTER_BURST_EN to allow back-to-back frames with SS held low.
module spi_master_00 #(
  parameter int unsigned CLKS_PER_HALF_BIT = 2,
  parameter int unsigned SS_GAP_HALF_BITS  = 2
) (
  input logic              P_CLK,
  input logic              reset,
  spi_master_00_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [7:0] H_LAST   = 8'(CLKS_PER_HALF_BIT - 1);
  localparam logic [7:0] GAP_LAST = 8'(SS_GAP_HALF_BITS - 1);

  state_t     state_r;
  state_t     state_s;
  logic [7:0] half_cnt_r;
  logic [7:0] gap_cnt_r;
  logic [3:0] phase_r;
  logic [7:0] tx_r;
  logic [7:0] rx_shift_r;
  logic [7:0] rx_data_r;
  logic       rx_dv_r;
  logic       sclk_r;
  logic       mosi_r;
  logic       tx_ready_s;
  logic       ss_s;
  logic       accept_s;
  logic       half_end_s;
  logic [2:0] next_bit_s;

  assign half_end_s = (half_cnt_r == H_LAST);
  assign accept_s   = bus.i_TX_DV & tx_ready_s;
  // Even phases are SCLK-high for bit phase/2; the following low phase shifts out the next bit.
  assign next_bit_s = phase_r[3:1] + 3'd1;

  // State register
  always_ff @(posedge P_CLK) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = SETUP;
        else          state_s = IDLE;
      end
      SETUP: begin
        if (half_end_s) state_s = XFER;
        else            state_s = SETUP;
      end
      XFER: begin
        if (half_end_s && (phase_r == 4'd15)) state_s = GAP;
        else                                  state_s = XFER;
      end
      GAP: begin
        if (accept_s)                                   state_s = SETUP;
        else if (half_end_s && (gap_cnt_r == GAP_LAST)) state_s = IDLE;
        else                                            state_s = GAP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode; in burst builds the frame-end cycle can also accept a byte
  always_comb begin
    tx_ready_s = 1'b0;
    ss_s       = 1'b1;
    if (state_r == IDLE) begin
      tx_ready_s = 1'b1;
    end
`ifdef SPI_MASTER_BURST_EN
    else if (rx_dv_r) begin
      tx_ready_s = 1'b1;
    end
`endif
    else begin
      tx_ready_s = 1'b0;
    end
    if ((state_r == SETUP) || (state_r == XFER)) begin
      ss_s = 1'b0;
    end
`ifdef SPI_MASTER_BURST_EN
    else if (rx_dv_r && bus.i_TX_DV) begin
      ss_s = 1'b0;
    end
`endif
    else begin
      ss_s = 1'b1;
    end
  end

  // Timing counters, shift registers and registered pin values
  always_ff @(posedge P_CLK) begin
    if (reset) begin
      half_cnt_r <= 8'd0;
      gap_cnt_r  <= 8'd0;
      phase_r    <= 4'd0;
      tx_r       <= 8'd0;
      rx_shift_r <= 8'd0;
      rx_data_r  <= 8'd0;
      rx_dv_r    <= 1'b0;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
    end else begin
      rx_dv_r <= 1'b0;
      case (state_r)
        IDLE: begin
          sclk_r <= 1'b0;
          if (accept_s) begin
            tx_r       <= bus.i_TX_DATA;
            mosi_r     <= bus.i_TX_DATA[0];
            half_cnt_r <= 8'd0;
          end else begin
            mosi_r <= 1'b0;
          end
        end
        SETUP: begin
          if (half_end_s) begin
            half_cnt_r    <= 8'd0;
            phase_r       <= 4'd0;
            sclk_r        <= 1'b1;
            rx_shift_r[0] <= bus.i_MISO;
          end else begin
            half_cnt_r <= half_cnt_r + 8'd1;
          end
        end
        XFER: begin
          if (!half_end_s) begin
            half_cnt_r <= half_cnt_r + 8'd1;
          end else if (phase_r == 4'd15) begin
            half_cnt_r <= 8'd0;
            gap_cnt_r  <= 8'd0;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            rx_data_r  <= rx_shift_r;
            rx_dv_r    <= 1'b1;
          end else if (!phase_r[0]) begin
            half_cnt_r <= 8'd0;
            phase_r    <= phase_r + 4'd1;
            sclk_r     <= 1'b0;
            if (phase_r != 4'd14) mosi_r <= tx_r[next_bit_s];
          end else begin
            half_cnt_r <= 8'd0;
            phase_r    <= phase_r + 4'd1;
            sclk_r     <= 1'b1;
            rx_shift_r[next_bit_s] <= bus.i_MISO;
          end
        end
        GAP: begin
          sclk_r <= 1'b0;
          if (accept_s) begin
            tx_r       <= bus.i_TX_DATA;
            mosi_r     <= bus.i_TX_DATA[0];
            half_cnt_r <= 8'd0;
          end else if (half_end_s) begin
            mosi_r     <= 1'b0;
            half_cnt_r <= 8'd0;
            gap_cnt_r  <= gap_cnt_r + 8'd1;
          end else begin
            mosi_r     <= 1'b0;
            half_cnt_r <= half_cnt_r + 8'd1;
          end
        end
        default: begin
          sclk_r <= 1'b0;
          mosi_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_TX_READY = tx_ready_s;
  assign bus.o_SS       = ss_s;
  assign bus.o_SCLK     = sclk_r;
  assign bus.o_MOSI     = mosi_r;
  assign bus.o_RX_DATA  = rx_data_r;
  assign bus.o_RX_DV    = rx_dv_r;

endmodule

// File: tb/tb_spi_master_00.sv
// Self-checking bench for spi_master_00: a default-timing instance and an H=1 instance,
// checked against frame-level expectations (bit order, edge times, pulse times).
module tb_spi_master_00;
  localparam int H0 = 2;
  localparam int G0 = 2;
  localparam int H1 = 1;
  localparam int G1 = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       dv;
  logic [7:0] data;
  logic       loop;
  logic       miso;
  int         errs = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  spi_master_00_if bus0 ();
  spi_master_00_if bus1 ();

  spi_master_00 #(.CLKS_PER_HALF_BIT(H0), .SS_GAP_HALF_BITS(G0)) dut0 (
    .P_CLK(clk), .reset(rst), .bus(bus0)
  );
  spi_master_00 #(.CLKS_PER_HALF_BIT(H1), .SS_GAP_HALF_BITS(G1)) dut1 (
    .P_CLK(clk), .reset(rst), .bus(bus1)
  );

  assign bus0.i_TX_DV   = dv & ~sel;
  assign bus1.i_TX_DV   = dv & sel;
  assign bus0.i_TX_DATA = data;
  assign bus1.i_TX_DATA = data;
  assign bus0.i_MISO    = loop ? bus0.o_MOSI : miso;
  assign bus1.i_MISO    = loop ? bus1.o_MOSI : miso;

  wire       m_sclk  = sel ? bus1.o_SCLK     : bus0.o_SCLK;
  wire       m_ss    = sel ? bus1.o_SS       : bus0.o_SS;
  wire       m_mosi  = sel ? bus1.o_MOSI     : bus0.o_MOSI;
  wire       m_ready = sel ? bus1.o_TX_READY : bus0.o_TX_READY;
  wire       m_rxdv  = sel ? bus1.o_RX_DV    : bus0.o_RX_DV;
  wire [7:0] m_rx    = sel ? bus1.o_RX_DATA  : bus0.o_RX_DATA;

  // One frame on the selected instance; called at a negedge with the instance idle.
  // Accept cycle is T; iteration n samples cycle T+n.
  task automatic run_frame(input logic s, input int h, input int g, input logic [7:0] tx,
                           input logic [7:0] mpat, input logic lp, input int inj_n);
    int         rise_n [8];
    logic [7:0] mosi_got;
    logic [7:0] exp_rx;
    int         rises, dv_cnt, dv_n, rdy_n, nmax, exp_rdy;
    logic       prev_sclk, ss_ok, sp_ok;
    sel = s;
    loop = lp;
    miso = mpat[0];
    #1;
    exp_rx = lp ? tx : mpat;
    nmax = 1 + 17 * h + g * h + 2;
`ifdef SPI_MASTER_BURST_EN
    exp_rdy = 1 + 17 * h;
`else
    exp_rdy = 1 + 17 * h + g * h;
`endif
    checks++;
    if (m_ready !== 1'b1) begin
      errs++; $display("FAIL ready_before_accept tx=%h: got %b want 1", tx, m_ready);
    end
    data = tx;
    dv = 1'b1;
    rises = 0; dv_cnt = 0; dv_n = -1; rdy_n = -1;
    prev_sclk = 1'b0; ss_ok = 1'b1; sp_ok = 1'b1; mosi_got = 8'h00;
    for (int k = 0; k < 8; k++) rise_n[k] = 0;
    for (int n = 1; n <= nmax; n++) begin
      @(negedge clk);
      if (m_sclk === 1'b1 && prev_sclk === 1'b0) begin
        if (rises < 8) begin
          rise_n[rises] = n;
          mosi_got[rises] = m_mosi;
        end
        rises++;
      end
      prev_sclk = m_sclk;
      if (m_rxdv === 1'b1) begin dv_cnt++; dv_n = n; end
      if (m_ready === 1'b1 && rdy_n < 0) rdy_n = n;
      if (n <= 17 * h) begin
        if (m_ss !== 1'b0) ss_ok = 1'b0;
      end else if (n == 17 * h + 1) begin
        if (m_ss !== 1'b1 || m_sclk !== 1'b0 || m_mosi !== 1'b0) ss_ok = 1'b0;
      end
      if (rises < 8) miso = mpat[rises];
      dv = (n == inj_n) ? 1'b1 : 1'b0;
      data = (n == inj_n) ? 8'h00 : 8'($urandom);
    end
    dv = 1'b0;
    for (int k = 0; k < 8; k++) if (rise_n[k] != 1 + h + 2 * h * k) sp_ok = 1'b0;
    checks++;
    if (rises != 8) begin errs++; $display("FAIL sclk_rises tx=%h: got %0d want 8", tx, rises); end
    checks++;
    if (mosi_got !== tx) begin errs++; $display("FAIL mosi_bits: got %h want %h", mosi_got, tx); end
    checks++;
    if (sp_ok !== 1'b1) begin
      errs++; $display("FAIL sclk_timing tx=%h: first rise at %0d want %0d", tx, rise_n[0], 1 + h);
    end
    checks++;
    if (dv_cnt != 1) begin errs++; $display("FAIL rx_dv_count tx=%h: got %0d want 1", tx, dv_cnt); end
    checks++;
    if (dv_n != 1 + 17 * h) begin errs++; $display("FAIL rx_dv_time: got T+%0d want T+%0d", dv_n, 1 + 17 * h); end
    checks++;
    if (rdy_n != exp_rdy) begin errs++; $display("FAIL ready_time: got T+%0d want T+%0d", rdy_n, exp_rdy); end
    checks++;
    if (m_rx !== exp_rx) begin errs++; $display("FAIL rx_data: got %h want %h", m_rx, exp_rx); end
    checks++;
    if (ss_ok !== 1'b1) begin errs++; $display("FAIL ss_window tx=%h: ss/sclk/mosi wrong around frame", tx); end
  endtask

  task automatic test_reset();
    sel = 1'b0; dv = 1'b0; data = 8'h00; loop = 1'b0; miso = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus0.o_SS, bus0.o_SCLK, bus0.o_MOSI, bus0.o_RX_DV, bus0.o_TX_READY} !== 5'b10001) begin
      errs++; $display("FAIL reset_pins0: got %b want 10001",
                       {bus0.o_SS, bus0.o_SCLK, bus0.o_MOSI, bus0.o_RX_DV, bus0.o_TX_READY});
    end
    checks++;
    if ({bus1.o_SS, bus1.o_SCLK, bus1.o_MOSI, bus1.o_RX_DV, bus1.o_TX_READY} !== 5'b10001) begin
      errs++; $display("FAIL reset_pins1: got %b want 10001",
                       {bus1.o_SS, bus1.o_SCLK, bus1.o_MOSI, bus1.o_RX_DV, bus1.o_TX_READY});
    end
    checks++;
    if (bus0.o_RX_DATA !== 8'h00) begin errs++; $display("FAIL reset_rx0: got %h want 00", bus0.o_RX_DATA); end
    rst = 1'b0;
  endtask

  task automatic test_loopback_a5();
    run_frame(1'b0, H0, G0, 8'hA5, 8'h00, 1'b1, 0);
  endtask

  task automatic test_fast_clock();
    run_frame(1'b1, H1, G1, 8'h3C, 8'hFF, 1'b0, 0);
  endtask

  task automatic test_ignore_mid_frame();
    run_frame(1'b0, H0, G0, 8'h96, 8'h00, 1'b1, 10);
  endtask

  task automatic test_random();
    logic s;
    for (int i = 0; i < 6; i++) begin
      s = (i % 2) == 1;
      run_frame(s, s ? H1 : H0, s ? G1 : G0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0);
    end
  endtask

`ifdef SPI_MASTER_BURST_EN
  task automatic test_burst();
    int         dvt [2];
    logic [7:0] rxv [2];
    int         nd;
    logic       ss_ok;
    sel = 1'b0; loop = 1'b1; #1;
    data = 8'h12; dv = 1'b1;
    nd = 0; ss_ok = 1'b1; dvt[0] = -1; dvt[1] = -1; rxv[0] = 8'h00; rxv[1] = 8'h00;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) data = 8'h34;
      if (n == 36) dv = 1'b0;
      if (bus0.o_RX_DV === 1'b1 && nd < 2) begin dvt[nd] = n; rxv[nd] = bus0.o_RX_DATA; nd++; end
      if (n <= 34 * H0 && bus0.o_SS !== 1'b0) ss_ok = 1'b0;
      if (n == 34 * H0 + 1 && bus0.o_SS !== 1'b1) ss_ok = 1'b0;
    end
    checks++;
    if (dvt[0] != 1 + 17 * H0 || dvt[1] != 1 + 34 * H0) begin
      errs++; $display("FAIL burst_dv_times: got %0d,%0d want %0d,%0d", dvt[0], dvt[1], 1 + 17 * H0, 1 + 34 * H0);
    end
    checks++;
    if (rxv[0] !== 8'h12 || rxv[1] !== 8'h34) begin
      errs++; $display("FAIL burst_rx: got %h,%h want 12,34", rxv[0], rxv[1]);
    end
    checks++;
    if (ss_ok !== 1'b1) begin errs++; $display("FAIL burst_ss: ss not held low across both frames"); end
  endtask
`else
  task automatic test_back_to_back();
    int   hi_run, frames_low;
    logic prev_ss, done, rdy_seen;
    sel = 1'b0; loop = 1'b1; #1;
    data = 8'h5A; dv = 1'b1;
    hi_run = 0; frames_low = 0; prev_ss = 1'b1; done = 1'b0;
    for (int n = 1; n <= 200 && !done; n++) begin
      @(negedge clk);
      if (bus0.o_SS === 1'b0 && prev_ss === 1'b1) frames_low++;
      if (frames_low == 1 && bus0.o_SS === 1'b1) hi_run++;
      if (frames_low == 2) done = 1'b1;
      prev_ss = bus0.o_SS;
    end
    dv = 1'b0;
    checks++;
    if (done !== 1'b1) begin errs++; $display("FAIL b2b_second_frame: got %b want 1", done); end
    checks++;
    if (hi_run != G0 * H0 + 1) begin errs++; $display("FAIL b2b_ss_gap: got %0d want %0d", hi_run, G0 * H0 + 1); end
    checks++;
    if (hi_run < 2 * H0) begin errs++; $display("FAIL b2b_ss_min: got %0d want >=%0d", hi_run, 2 * H0); end
    rdy_seen = 1'b0;
    for (int n = 0; n < 100 && !rdy_seen; n++) begin
      @(negedge clk);
      if (bus0.o_TX_READY === 1'b1) rdy_seen = 1'b1;
    end
    checks++;
    if (rdy_seen !== 1'b1) begin errs++; $display("FAIL b2b_return_idle: got %b want 1", rdy_seen); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int dv_seen, sclk_seen;
    run_frame(1'b0, H0, G0, 8'hC3, 8'h00, 1'b1, 0);
    data = 8'hF0; dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus0.o_SS, bus0.o_SCLK, bus0.o_TX_READY} !== 3'b101) begin
      errs++; $display("FAIL abort_pins: got %b want 101", {bus0.o_SS, bus0.o_SCLK, bus0.o_TX_READY});
    end
    dv_seen = 0; sclk_seen = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus0.o_RX_DV === 1'b1) dv_seen++;
      if (bus0.o_SCLK === 1'b1) sclk_seen++;
    end
    checks++;
    if (dv_seen != 0 || sclk_seen != 0) begin
      errs++; $display("FAIL abort_quiet: rx_dv=%0d sclk_high=%0d want 0,0", dv_seen, sclk_seen);
    end
    checks++;
    if (bus0.o_RX_DATA !== 8'h00) begin errs++; $display("FAIL abort_rx: got %h want 00", bus0.o_RX_DATA); end
  endtask

  task automatic test_reset_vs_accept();
    int ss_low;
    sel = 1'b0;
    data = 8'($urandom); dv = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; dv = 1'b0;
    ss_low = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus0.o_SS === 1'b0) ss_low++;
    end
    checks++;
    if (ss_low != 0) begin errs++; $display("FAIL reset_priority: ss low %0d cycles want 0", ss_low); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loopback_a5();
    test_fast_clock();
    test_ignore_mid_frame();
    test_random();
`ifdef SPI_MASTER_BURST_EN
    test_burst();
`else
    test_back_to_back();
`endif
    test_reset_mid_frame();
    test_reset_vs_accept();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
